// File: rtl/amba_lite_input_stage.sv
// Per-master input stage of the multi-layer AHB-lite interconnect.
// Decodes the target slave port, presents a held request with a one-hot HSEL
// to every output stage, stalls the master until the addressed output stage
// grants it, and returns the selected slave's response. Unmapped addresses
// receive a two-cycle ERROR from a built-in default slave.

`ifndef W_TRANS
`define W_TRANS 2
`endif
`ifndef W_BURST
`define W_BURST 3
`endif
`ifndef W_SIZE
`define W_SIZE 3
`endif
`ifndef W_PROT
`define W_PROT 4
`endif
`ifndef W_RESP
`define W_RESP 1
`endif

module amba_lite_input_stage #(
  parameter int N_SLAVE       = 4,
  parameter int W_SLAVE       = 2,
  parameter int W_ADDR        = 32,
  parameter int W_DATA        = 32,
  parameter int SLAVE_SEL_LSB = 28
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [`W_TRANS-1:0]         ma_HTRANS,
  input  logic [`W_BURST-1:0]         ma_HBURST,
  input  logic [`W_SIZE-1:0]          ma_HSIZE,
  input  logic [`W_PROT-1:0]          ma_HPROT,
  input  logic                        ma_HMASTLOCK,
  input  logic [W_ADDR-1:0]           ma_HADDR,
  input  logic                        ma_HWRITE,
  input  logic [W_DATA-1:0]           ma_HWDATA,
  output logic                        out_ma_HREADY,
  output logic [`W_RESP-1:0]          out_ma_HRESP,
  output logic [W_DATA-1:0]           out_ma_HRDATA,
  input  logic [N_SLAVE-1:0]          sl_active,
  input  logic [N_SLAVE-1:0]          sl_HREADY,
  input  logic [N_SLAVE*`W_RESP-1:0]  sl_HRESP,
  input  logic [N_SLAVE*W_DATA-1:0]   sl_HRDATA,
  output logic [N_SLAVE-1:0]          out_HSEL,
  output logic                        out_held_trans,
  output logic [`W_TRANS-1:0]         out_HTRANS,
  output logic [`W_BURST-1:0]         out_HBURST,
  output logic [`W_SIZE-1:0]          out_HSIZE,
  output logic [`W_PROT-1:0]          out_HPROT,
  output logic                        out_HMASTLOCK,
  output logic [W_ADDR-1:0]           out_HADDR,
  output logic                        out_HWRITE,
  output logic [W_DATA-1:0]           out_HWDATA,
  output logic [2:0]                  q_state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HOLD = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  localparam logic [`W_RESP-1:0] RESP_OKAY  = `W_RESP'(0);
  localparam logic [`W_RESP-1:0] RESP_ERROR = `W_RESP'(1);

  logic [2:0]          r_state;
  logic [N_SLAVE-1:0]  r_dsHot;
  logic [`W_TRANS-1:0] r_trans;
  logic [`W_BURST-1:0] r_burst;
  logic [`W_SIZE-1:0]  r_size;
  logic [`W_PROT-1:0]  r_prot;
  logic                r_lock;
  logic [W_ADDR-1:0]   r_addr;
  logic                r_write;

  logic [W_SLAVE-1:0]  w_decIdx;
  logic [N_SLAVE-1:0]  w_decHot;
  logic                w_decValid;
  logic                w_decGo;
  logic                w_dsReady;
  logic                w_dsActive;
  logic [`W_RESP-1:0]  w_dsResp;
  logic [W_DATA-1:0]   w_dsRdata;
  logic                w_accept;
  logic                w_request;
  logic                w_validReq;
  logic [2:0]          w_nextState;

  assign w_decIdx = ma_HADDR[SLAVE_SEL_LSB +: W_SLAVE];

  // Address decode to one-hot; an index beyond the last port yields all zeros
  always_comb begin
    w_decHot = '0;
    for (int s = 0; s < N_SLAVE; s++) begin
      w_decHot[s] = (w_decIdx == W_SLAVE'(s));
    end
  end

  assign w_decValid = |w_decHot;
  assign w_decGo    = |(w_decHot & sl_active & sl_HREADY);

  // Select the response of the output stage owning the current data phase
  always_comb begin
    w_dsResp  = '0;
    w_dsRdata = '0;
    for (int s = 0; s < N_SLAVE; s++) begin
      if (r_dsHot[s]) begin
        w_dsResp  |= sl_HRESP[s*`W_RESP +: `W_RESP];
        w_dsRdata |= sl_HRDATA[s*W_DATA +: W_DATA];
      end
    end
  end

  assign w_dsReady  = |(r_dsHot & sl_HREADY);
  assign w_dsActive = |(r_dsHot & sl_active);

  // A cycle in which the master sees HREADY high and may issue a new address
  assign w_accept = (r_state == ST_IDLE) || (r_state == ST_ERR2) ||
                    ((r_state == ST_DATA) && w_dsReady);

  // Reset gating keeps HSEL and the request low while HRESETn is held
  assign w_request  = w_accept && ma_HTRANS[1] && HRESETn;
  assign w_validReq = w_request && w_decValid;

  // Next-state selection; DATA completion is treated exactly like IDLE
  always_comb begin
    w_nextState = ST_IDLE;
    if (w_accept) begin
      if (!w_request)       w_nextState = ST_IDLE;
      else if (!w_decValid) w_nextState = ST_ERR1;
      else if (w_decGo)     w_nextState = ST_DATA;
      else                  w_nextState = ST_HOLD;
    end else begin
      case (r_state)
        ST_HOLD: w_nextState = (w_dsActive && w_dsReady) ? ST_DATA : ST_HOLD;
        ST_DATA: w_nextState = ST_DATA;
        ST_ERR1: w_nextState = ST_ERR2;
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

  // Master-side response: stall in HOLD/ERR1, pass slave response in DATA
  always_comb begin
    out_ma_HREADY = 1'b1;
    out_ma_HRESP  = RESP_OKAY;
    out_ma_HRDATA = '0;
    case (r_state)
      ST_HOLD: out_ma_HREADY = 1'b0;
      ST_DATA: begin
        out_ma_HREADY = w_dsReady;
        out_ma_HRESP  = w_dsResp;
        out_ma_HRDATA = w_dsRdata;
      end
      ST_ERR1: begin
        out_ma_HREADY = 1'b0;
        out_ma_HRESP  = RESP_ERROR;
      end
      ST_ERR2: out_ma_HRESP = RESP_ERROR;
      default: ;
    endcase
  end

  // Slave-side presentation: live master signals when accepting, else held copy
  always_comb begin
    out_HTRANS     = w_accept ? ma_HTRANS    : r_trans;
    out_HBURST     = w_accept ? ma_HBURST    : r_burst;
    out_HSIZE      = w_accept ? ma_HSIZE     : r_size;
    out_HPROT      = w_accept ? ma_HPROT     : r_prot;
    out_HMASTLOCK  = w_accept ? ma_HMASTLOCK : r_lock;
    out_HADDR      = w_accept ? ma_HADDR     : r_addr;
    out_HWRITE     = w_accept ? ma_HWRITE    : r_write;
    out_held_trans = 1'b0;
    out_HSEL       = '0;
    if (w_validReq) begin
      out_held_trans = 1'b1;
      out_HSEL       = w_decHot;
    end else if (r_state == ST_HOLD) begin
      out_held_trans = 1'b1;
      out_HSEL       = r_dsHot;
    end
  end

  assign out_HWDATA = ma_HWDATA;
  assign q_state    = r_state;

  // State register and address-phase capture on every accept cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_dsHot <= '0;
      r_trans <= '0;
      r_burst <= '0;
      r_size  <= '0;
      r_prot  <= '0;
      r_lock  <= 1'b0;
      r_addr  <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_trans <= ma_HTRANS;
        r_burst <= ma_HBURST;
        r_size  <= ma_HSIZE;
        r_prot  <= ma_HPROT;
        r_lock  <= ma_HMASTLOCK;
        r_addr  <= ma_HADDR;
        r_write <= ma_HWRITE;
      end
      if (w_validReq) begin
        r_dsHot <= w_decHot;
      end
    end
  end

endmodule

// File: tb/tb_amba_lite_input_stage.sv
// Directed, table-driven bench for amba_lite_input_stage. Four slave ports
// with a three-bit decode field, so addresses 0x4000_0000..0x7FFF_FFFF are
// unmapped and reach the default slave.

module tb_amba_lite_input_stage;

  localparam int N_SLAVE = 4;
  localparam int W_SLAVE = 3;

  logic        HCLK;
  logic        HRESETn;
  logic [1:0]  ma_HTRANS;
  logic [2:0]  ma_HBURST;
  logic [2:0]  ma_HSIZE;
  logic [3:0]  ma_HPROT;
  logic        ma_HMASTLOCK;
  logic [31:0] ma_HADDR;
  logic        ma_HWRITE;
  logic [31:0] ma_HWDATA;
  logic        out_ma_HREADY;
  logic [0:0]  out_ma_HRESP;
  logic [31:0] out_ma_HRDATA;
  logic [3:0]  sl_active;
  logic [3:0]  sl_HREADY;
  logic [3:0]  sl_HRESP;
  logic [127:0] sl_HRDATA;
  logic [3:0]  out_HSEL;
  logic        out_held_trans;
  logic [1:0]  out_HTRANS;
  logic [2:0]  out_HBURST;
  logic [2:0]  out_HSIZE;
  logic [3:0]  out_HPROT;
  logic        out_HMASTLOCK;
  logic [31:0] out_HADDR;
  logic        out_HWRITE;
  logic [31:0] out_HWDATA;
  logic [2:0]  q_state;

  int nChecks = 0;
  int nFails  = 0;

  amba_lite_input_stage #(
    .N_SLAVE(N_SLAVE), .W_SLAVE(W_SLAVE), .W_ADDR(32), .W_DATA(32), .SLAVE_SEL_LSB(28)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .ma_HTRANS(ma_HTRANS), .ma_HBURST(ma_HBURST), .ma_HSIZE(ma_HSIZE),
    .ma_HPROT(ma_HPROT), .ma_HMASTLOCK(ma_HMASTLOCK), .ma_HADDR(ma_HADDR),
    .ma_HWRITE(ma_HWRITE), .ma_HWDATA(ma_HWDATA),
    .out_ma_HREADY(out_ma_HREADY), .out_ma_HRESP(out_ma_HRESP), .out_ma_HRDATA(out_ma_HRDATA),
    .sl_active(sl_active), .sl_HREADY(sl_HREADY), .sl_HRESP(sl_HRESP), .sl_HRDATA(sl_HRDATA),
    .out_HSEL(out_HSEL), .out_held_trans(out_held_trans),
    .out_HTRANS(out_HTRANS), .out_HBURST(out_HBURST), .out_HSIZE(out_HSIZE),
    .out_HPROT(out_HPROT), .out_HMASTLOCK(out_HMASTLOCK), .out_HADDR(out_HADDR),
    .out_HWRITE(out_HWRITE), .out_HWDATA(out_HWDATA), .q_state(q_state)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  typedef struct {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [3:0]  act;
    logic [3:0]  rdy;
    logic [3:0]  rsp;
    logic        eRdy;
    logic        eRsp;
    logic [3:0]  eSel;
    logic        eHeld;
    logic [2:0]  eState;
    logic [31:0] eRdata;
    logic [31:0] eAddr;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mkVec(logic [1:0] trans, logic [31:0] addr, logic [3:0] act,
                                 logic [3:0] rdy, logic [3:0] rsp, logic eRdy, logic eRsp,
                                 logic [3:0] eSel, logic eHeld, logic [2:0] eState,
                                 logic [31:0] eRdata, logic [31:0] eAddr);
    vec_t v;
    v.trans = trans; v.addr = addr; v.act = act; v.rdy = rdy; v.rsp = rsp;
    v.eRdy = eRdy; v.eRsp = eRsp; v.eSel = eSel; v.eHeld = eHeld;
    v.eState = eState; v.eRdata = eRdata; v.eAddr = eAddr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] trans, input logic [31:0] addr,
                               input logic [3:0] act, input logic [3:0] rdy, input logic [3:0] rsp);
    ma_HTRANS = trans;
    ma_HADDR  = addr;
    ma_HWRITE = trans[1];
    sl_active = act;
    sl_HREADY = rdy;
    sl_HRESP  = rsp;
  endtask

  initial begin
    // Slice s of read data is 0xD000_000s so the selected slave is visible
    sl_HRDATA    = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    ma_HBURST    = 3'd0;
    ma_HSIZE     = 3'd2;
    ma_HPROT     = 4'd3;
    ma_HMASTLOCK = 1'b0;
    ma_HWDATA    = 32'h0;
    HRESETn      = 1'b0;
    applyStimulus(2'b00, 32'h0, 4'h0, 4'hF, 4'h0);

    // Cycle-by-cycle vectors: inputs, then expected outputs before the edge
    vecs[0]  = mkVec(2'b00, 32'h0000_0000, 4'h0, 4'hF, 4'h0, 1, 0, 4'h0, 0, 3'd0, 32'h0,         32'h0000_0000);
    vecs[1]  = mkVec(2'b10, 32'h1000_0000, 4'h2, 4'hF, 4'h0, 1, 0, 4'h2, 1, 3'd0, 32'h0,         32'h1000_0000);
    vecs[2]  = mkVec(2'b00, 32'h0000_0000, 4'h0, 4'hF, 4'h0, 1, 0, 4'h0, 0, 3'd2, 32'hD000_0001, 32'h0000_0000);
    vecs[3]  = mkVec(2'b10, 32'h2000_0004, 4'h0, 4'hF, 4'h0, 1, 0, 4'h4, 1, 3'd0, 32'h0,         32'h2000_0004);
    vecs[4]  = mkVec(2'b10, 32'hFFFF_FFFF, 4'h0, 4'hF, 4'h0, 0, 0, 4'h4, 1, 3'd1, 32'h0,         32'h2000_0004);
    vecs[5]  = mkVec(2'b10, 32'hFFFF_FFFF, 4'h0, 4'hF, 4'h0, 0, 0, 4'h4, 1, 3'd1, 32'h0,         32'h2000_0004);
    vecs[6]  = mkVec(2'b10, 32'hFFFF_FFFF, 4'h0, 4'hF, 4'h0, 0, 0, 4'h4, 1, 3'd1, 32'h0,         32'h2000_0004);
    vecs[7]  = mkVec(2'b00, 32'h0000_0000, 4'h4, 4'hF, 4'h0, 0, 0, 4'h4, 1, 3'd1, 32'h0,         32'h2000_0004);
    vecs[8]  = mkVec(2'b00, 32'h0000_0000, 4'h0, 4'hF, 4'h0, 1, 0, 4'h0, 0, 3'd2, 32'hD000_0002, 32'h0000_0000);
    vecs[9]  = mkVec(2'b10, 32'h5000_0000, 4'hF, 4'hF, 4'h0, 1, 0, 4'h0, 0, 3'd0, 32'h0,         32'h5000_0000);
    vecs[10] = mkVec(2'b10, 32'h5000_0000, 4'hF, 4'hF, 4'h0, 0, 1, 4'h0, 0, 3'd3, 32'h0,         32'h5000_0000);
    vecs[11] = mkVec(2'b00, 32'h0000_0000, 4'hF, 4'hF, 4'h0, 1, 1, 4'h0, 0, 3'd4, 32'h0,         32'h0000_0000);
    vecs[12] = mkVec(2'b10, 32'h0000_0000, 4'h1, 4'hF, 4'h0, 1, 0, 4'h1, 1, 3'd0, 32'h0,         32'h0000_0000);
    vecs[13] = mkVec(2'b10, 32'h3000_0000, 4'h8, 4'hE, 4'h0, 0, 0, 4'h0, 0, 3'd2, 32'hD000_0000, 32'h0000_0000);
    vecs[14] = mkVec(2'b10, 32'h3000_0000, 4'h8, 4'hF, 4'h0, 1, 0, 4'h8, 1, 3'd2, 32'hD000_0000, 32'h3000_0000);
    vecs[15] = mkVec(2'b00, 32'h0000_0000, 4'h0, 4'h7, 4'h8, 0, 1, 4'h0, 0, 3'd2, 32'hD000_0003, 32'h3000_0000);
    vecs[16] = mkVec(2'b00, 32'h0000_0000, 4'h0, 4'hF, 4'h8, 1, 1, 4'h0, 0, 3'd2, 32'hD000_0003, 32'h0000_0000);
    vecs[17] = mkVec(2'b01, 32'h1000_0000, 4'hF, 4'hF, 4'h0, 1, 0, 4'h0, 0, 3'd0, 32'h0,         32'h1000_0000);
    vecs[18] = mkVec(2'b00, 32'h0000_0000, 4'h0, 4'hF, 4'h0, 1, 0, 4'h0, 0, 3'd0, 32'h0,         32'h0000_0000);

    // Reset state, with the master already requesting to prove gating
    @(posedge HCLK); #1;
    applyStimulus(2'b10, 32'h1000_0000, 4'hF, 4'hF, 4'h0);
    #2;
    checkOutput("rst_hready", 32'(out_ma_HREADY), 32'h1);
    checkOutput("rst_hresp", 32'(out_ma_HRESP), 32'h0);
    checkOutput("rst_hrdata", out_ma_HRDATA, 32'h0);
    checkOutput("rst_hsel", 32'(out_HSEL), 32'h0);
    checkOutput("rst_held", 32'(out_held_trans), 32'h0);
    checkOutput("rst_state", 32'(q_state), 32'h0);
    applyStimulus(2'b00, 32'h0, 4'h0, 4'hF, 4'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].trans, vecs[i].addr, vecs[i].act, vecs[i].rdy, vecs[i].rsp);
      ma_HWDATA = 32'hA5A5_0000 + 32'(i);
      #3;
      checkOutput($sformatf("v%0d_hready", i), 32'(out_ma_HREADY), 32'(vecs[i].eRdy));
      checkOutput($sformatf("v%0d_hresp", i), 32'(out_ma_HRESP), 32'(vecs[i].eRsp));
      checkOutput($sformatf("v%0d_hsel", i), 32'(out_HSEL), 32'(vecs[i].eSel));
      checkOutput($sformatf("v%0d_held", i), 32'(out_held_trans), 32'(vecs[i].eHeld));
      checkOutput($sformatf("v%0d_state", i), 32'(q_state), 32'(vecs[i].eState));
      checkOutput($sformatf("v%0d_hrdata", i), out_ma_HRDATA, vecs[i].eRdata);
      checkOutput($sformatf("v%0d_haddr", i), out_HADDR, vecs[i].eAddr);
      checkOutput($sformatf("v%0d_hwdata", i), out_HWDATA, 32'hA5A5_0000 + 32'(i));
      @(posedge HCLK); #1;
    end

    // Asynchronous reset while stalled in HOLD
    applyStimulus(2'b10, 32'h2000_0000, 4'h0, 4'hF, 4'h0);
    @(posedge HCLK); #1;
    checkOutput("hold_state", 32'(q_state), 32'h1);
    checkOutput("hold_hready", 32'(out_ma_HREADY), 32'h0);
    checkOutput("hold_hsel", 32'(out_HSEL), 32'h4);
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("arst_state", 32'(q_state), 32'h0);
    checkOutput("arst_hready", 32'(out_ma_HREADY), 32'h1);
    checkOutput("arst_held", 32'(out_held_trans), 32'h0);
    checkOutput("arst_hsel", 32'(out_HSEL), 32'h0);
    @(posedge HCLK); #1;
    applyStimulus(2'b00, 32'h0, 4'h0, 4'hF, 4'h0);
    HRESETn = 1'b1;
    #3;
    checkOutput("post_rst_state", 32'(q_state), 32'h0);
    checkOutput("post_rst_hready", 32'(out_ma_HREADY), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
